// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution block.
//   acc_width()   : accumulator width that can never overflow for a KSIZE x KSIZE
//                   sum of (signed coef x unsigned pixel) products.
//   ksize_legal() : true for odd kernel sides from 3 to 7.
//   clamp_round() : round-half-up arithmetic right shift, then clamp to an
//                   unsigned word of the given width.
//   coef_t        : default-width signed coefficient.
package conv_pkg;

    localparam int COEF_W_DEF = 8;

    typedef logic signed [COEF_W_DEF-1:0] coef_t;

    function automatic int acc_width(input int word_size, input int coef_w, input int ksize);
        return word_size + coef_w + $clog2(ksize * ksize) + 1;
    endfunction

    function automatic bit ksize_legal(input int ksize);
        return (ksize >= 3) && (ksize <= 7) && ((ksize % 2) == 1);
    endfunction

    // The sum is carried sign-extended to 64 bits so one function serves every
    // accumulator width; the result is truncated by the caller to WORD_SIZE.
    function automatic logic [31:0] clamp_round(input logic signed [63:0] sum,
                                                input logic [7:0]         shift,
                                                input int unsigned        wsize);
        logic signed [63:0] r;
        logic signed [63:0] max_val;
        r = sum;
        if (shift != 8'd0) begin
            r = r + (64'sd1 <<< (shift - 8'd1));
        end
        r       = r >>> shift;
        max_val = (64'sd1 <<< wsize) - 64'sd1;
        if (r < 0) begin
            return 32'd0;
        end else if (r > max_val) begin
            return max_val[31:0];
        end else begin
            return r[31:0];
        end
    endfunction

endpackage

// File: rtl/line_window.sv
// KSIZE-1 line buffers plus a KSIZE x KSIZE sliding window.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset (clears the window registers)
//   shift_en  : an input pixel is accepted this cycle
//   col       : column of the accepted pixel within its line
//   pixel     : accepted pixel
//   window    : window[r][c], r=0 oldest line, c=0 oldest column
module line_window #(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 10,
    parameter int KSIZE     = 3,
    parameter int COL_W     = $clog2(ROW_SIZE)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         shift_en,
    input  logic [COL_W-1:0]                             col,
    input  logic [WORD_SIZE-1:0]                         pixel,
    output logic [KSIZE-1:0][KSIZE-1:0][WORD_SIZE-1:0]   window
);

    // line_mem[j] holds the line that is j+1 lines older than the incoming one.
    logic [WORD_SIZE-1:0] line_mem [KSIZE-1][ROW_SIZE];

    logic [KSIZE-1:0][WORD_SIZE-1:0]             new_col;
    logic [KSIZE-1:0][KSIZE-1:0][WORD_SIZE-1:0]  window_reg;
    logic [KSIZE-1:0][KSIZE-1:0][WORD_SIZE-1:0]  window_next;

    // Column entering the window: the newest row is the live pixel, older rows
    // come from the line buffers at the same column.
    assign new_col[KSIZE-1] = pixel;
    for (genvar gi = 0; gi < KSIZE - 1; gi++) begin : g_col_tap
        assign new_col[gi] = line_mem[KSIZE-2-gi][col];
    end

    // Line buffers cascade at the current column; no reset is needed because
    // stale contents are masked by the row/column counters in the top.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            line_mem[0][col] <= pixel;
            for (int j = 1; j < KSIZE - 1; j++) begin
                line_mem[j][col] <= line_mem[j-1][col];
            end
        end
    end

    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < KSIZE; gj++) begin : g_colw
            if (gj == KSIZE - 1) begin : g_new
                assign window_next[gi][gj] = new_col[gi];
            end else begin : g_old
                assign window_next[gi][gj] = window_reg[gi][gj+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_reg <= '0;
        end else if (shift_en) begin
            window_reg <= window_next;
        end
    end

    assign window = window_reg;

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KSIZE x KSIZE convolution, "valid" crop, saturated unsigned output.
//   clk / rst            : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake; in_sof marks pixel (0,0) of a frame
//   inputPixel           : raster-order unsigned pixel
//   out_valid / out_ready: output handshake; outputPixel is the clamped result
//   coef_we/addr/data    : writes one shadow coefficient (index row*KSIZE+col)
//   cfg_shift            : right shift of the sum, captured at an accepted SOF
// Pipeline: window -> S1 products -> S2 sum -> S3 round/clamp; everything
// advances only when the output register can move (en).
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 10,
    parameter int KSIZE     = 3,
    parameter int COEF_W    = 8,
    parameter int SHIFT_W   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_sof,
    input  logic [WORD_SIZE-1:0]               inputPixel,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WORD_SIZE-1:0]               outputPixel,
    input  logic                               coef_we,
    input  logic [$clog2(KSIZE*KSIZE)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]           coef_data,
    input  logic [SHIFT_W-1:0]                 cfg_shift
);

    // An illegal kernel side collapses the coefficient count to zero, which
    // makes the coefficient arrays zero-sized and stops elaboration.
    localparam bit KSIZE_OK      = ksize_legal(KSIZE);
    localparam int KSIZE_CHECKED = KSIZE_OK ? KSIZE : 0;
    localparam int N             = KSIZE_CHECKED * KSIZE_CHECKED;
    localparam int ADDR_W        = $clog2(KSIZE * KSIZE);
    localparam int ACC_W         = acc_width(WORD_SIZE, COEF_W, KSIZE);
    localparam int PROD_W        = WORD_SIZE + COEF_W + 1;
    localparam int COL_W         = $clog2(ROW_SIZE);
    localparam int ROW_W         = $clog2(KSIZE);

    logic en;
    logic accept;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // ---------------- position counters ----------------
    logic [COL_W-1:0] col_reg, pos_col, col_next;
    logic [ROW_W-1:0] row_reg, pos_row, row_next;
    logic             win_done;

    // An SOF pixel is placed at (0,0) regardless of where the counters were.
    always_comb begin
        pos_col  = in_sof ? '0 : col_reg;
        pos_row  = in_sof ? '0 : row_reg;
        win_done = (pos_row == ROW_W'(KSIZE - 1)) && (pos_col >= COL_W'(KSIZE - 1));
        col_next = pos_col + COL_W'(1);
        row_next = pos_row;
        if (pos_col == COL_W'(ROW_SIZE - 1)) begin
            col_next = '0;
            if (pos_row != ROW_W'(KSIZE - 1)) begin
                row_next = pos_row + ROW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // ---------------- coefficient banks ----------------
    logic signed [COEF_W-1:0] shadow_coef_reg [N];
    logic signed [COEF_W-1:0] active_coef_reg [N];
    logic [SHIFT_W-1:0]       shift_active_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                shadow_coef_reg[i] <= '0;
                active_coef_reg[i] <= '0;
            end
            shift_active_reg <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (coef_we && (coef_addr == ADDR_W'(i))) begin
                    shadow_coef_reg[i] <= coef_data;
                end
                // A write in the SOF cycle bypasses into the active bank.
                if (accept && in_sof) begin
                    active_coef_reg[i] <= (coef_we && (coef_addr == ADDR_W'(i)))
                                          ? coef_data : shadow_coef_reg[i];
                end
            end
            if (accept && in_sof) begin
                shift_active_reg <= cfg_shift;
            end
        end
    end

    // ---------------- window ----------------
    logic [KSIZE-1:0][KSIZE-1:0][WORD_SIZE-1:0] window;
    logic                                       win_valid_reg;

    line_window #(
        .WORD_SIZE (WORD_SIZE),
        .ROW_SIZE  (ROW_SIZE),
        .KSIZE     (KSIZE),
        .COL_W     (COL_W)
    ) u_line_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .col      (pos_col),
        .pixel    (inputPixel),
        .window   (window)
    );

    // ---------------- S1: products ----------------
    logic signed [PROD_W-1:0] prod_next [N];
    logic signed [PROD_W-1:0] prod_reg  [N];
    logic                     s1_valid_reg;
    logic [SHIFT_W-1:0]       s1_shift_reg;

    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                prod_next[r*KSIZE+c] = PROD_W'($signed({1'b0, window[r][c]}))
                                     * PROD_W'(active_coef_reg[r*KSIZE+c]);
            end
        end
    end

    // ---------------- S2: sum ----------------
    logic signed [ACC_W-1:0] sum_next;
    logic signed [ACC_W-1:0] sum_reg;
    logic                    s2_valid_reg;
    logic [SHIFT_W-1:0]      s2_shift_reg;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < N; i++) begin
            sum_next = sum_next + ACC_W'(prod_reg[i]);
        end
    end

    // ---------------- S3: round / clamp ----------------
    logic [WORD_SIZE-1:0] pix_next;
    logic [WORD_SIZE-1:0] out_pix_reg;
    logic                 out_valid_reg;

    assign pix_next = WORD_SIZE'(clamp_round(64'(sum_reg), 8'(s2_shift_reg), WORD_SIZE));

    // The shift travels with its data so results of a previous frame still in
    // flight at an SOF use the shift they started with.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid_reg <= 1'b0;
            for (int i = 0; i < N; i++) begin
                prod_reg[i] <= '0;
            end
            s1_valid_reg  <= 1'b0;
            s1_shift_reg  <= '0;
            sum_reg       <= '0;
            s2_valid_reg  <= 1'b0;
            s2_shift_reg  <= '0;
            out_pix_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else if (en) begin
            win_valid_reg <= accept && win_done;
            prod_reg      <= prod_next;
            s1_valid_reg  <= win_valid_reg;
            s1_shift_reg  <= shift_active_reg;
            sum_reg       <= sum_next;
            s2_valid_reg  <= s1_valid_reg;
            s2_shift_reg  <= s1_shift_reg;
            out_pix_reg   <= pix_next;
            out_valid_reg <= s2_valid_reg;
        end
    end

    assign out_valid   = out_valid_reg;
    assign outputPixel = out_pix_reg;

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;

    localparam int W   = 8;
    localparam int ROW = 10;
    localparam int K   = 3;
    localparam int CW  = 8;
    localparam int SW  = 4;
    localparam int AW  = $clog2(K*K);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_sof = 1'b0;
    logic [W-1:0]         inputPixel = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [W-1:0]         outputPixel;
    logic                 coef_we = 1'b0;
    logic [AW-1:0]        coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic [SW-1:0]        cfg_shift = '0;

    conv2d_stream #(
        .WORD_SIZE (W), .ROW_SIZE (ROW), .KSIZE (K), .COEF_W (CW), .SHIFT_W (SW)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_sof (in_sof), .inputPixel (inputPixel),
        .out_valid (out_valid), .out_ready (out_ready), .outputPixel (outputPixel),
        .coef_we (coef_we), .coef_addr (coef_addr), .coef_data (coef_data), .cfg_shift (cfg_shift)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] fb [0:ROW*10-1];

    // 0 ramp r*10+c, 1 flat 100, 2 dot 255 at (4,5), 3 flat 255, 4 flat 8, 5 random
    task automatic fill(input int pat, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < ROW; c++) begin
                case (pat)
                    0: fb[r*ROW+c] = 8'(r*10 + c);
                    1: fb[r*ROW+c] = 8'd100;
                    2: fb[r*ROW+c] = (r == 4 && c == 5) ? 8'd255 : 8'd0;
                    3: fb[r*ROW+c] = 8'd255;
                    4: fb[r*ROW+c] = 8'd8;
                    default: fb[r*ROW+c] = 8'($urandom_range(255));
                endcase
            end
        end
    endtask

    task automatic load_coefs(input int kin[9]);
        for (int i = 0; i < K*K; i++) begin
            @(posedge clk); #1;
            coef_we   = 1'b1;
            coef_addr = AW'(i);
            coef_data = kin[i][7:0];
        end
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // mode 0: full rate, 1: random valid/ready, 2: full rate with a 5-cycle stall
    task automatic run_frame(input string name, input int h, input int kin[9], input int sh, input int mode);
        logic [7:0] exp_q[$];
        int nexp;
        int acc_edge;
        int first_out;
        acc_edge  = -1;
        first_out = -1;
        for (int r = K-1; r < h; r++) begin
            for (int c = K-1; c < ROW; c++) begin
                longint s;
                s = 0;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        s += longint'(kin[i*K+j]) * longint'(fb[(r-K+1+i)*ROW + (c-K+1+j)]);
                    end
                end
                if (sh > 0) s += (longint'(1) << (sh-1));
                s = s >>> sh;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                exp_q.push_back(8'(s));
            end
        end
        nexp = exp_q.size();
        fork
            begin : drive
                int idx;
                int guard;
                idx   = 0;
                guard = 0;
                while (idx < h*ROW && guard < 20000) begin
                    @(posedge clk); #1;
                    in_valid   = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
                    inputPixel = fb[idx];
                    in_sof     = (idx == 0);
                    @(negedge clk);
                    if (in_valid && in_ready) begin
                        if (idx == (K-1)*ROW + K-1) acc_edge = cyc + 1;
                        idx++;
                    end
                    guard++;
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
            begin : collect
                int got_n;
                int cycles;
                int extra;
                bit stalled;
                bit held;
                logic [7:0] hold;
                got_n   = 0;
                cycles  = 0;
                extra   = 0;
                stalled = 1'b0;
                held    = 1'b0;
                hold    = '0;
                while (got_n < nexp && cycles < 5000) begin
                    @(posedge clk); #1;
                    if (mode == 2 && !stalled && got_n == 10) begin
                        stalled   = 1'b1;
                        out_ready = 1'b0;
                        for (int s = 0; s < 5; s++) begin
                            @(negedge clk);
                            if (out_valid) begin
                                if (!held) begin
                                    hold = outputPixel;
                                    held = 1'b1;
                                end else begin
                                    check({name, "_stall_hold"}, 64'(outputPixel), 64'(hold));
                                end
                                check({name, "_stall_in_ready"}, 64'(in_ready), 64'(0));
                            end
                            @(posedge clk); #1;
                        end
                        out_ready = 1'b1;
                    end else begin
                        out_ready = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
                    end
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (first_out < 0) first_out = cyc;
                        check(name, 64'(outputPixel), 64'(exp_q.pop_front()));
                        got_n++;
                    end
                    cycles++;
                end
                if (got_n != nexp) check({name, "_timeout"}, 64'(got_n), 64'(nexp));
                @(posedge clk); #1;
                out_ready = 1'b1;
                for (int s = 0; s < 6; s++) begin
                    @(negedge clk);
                    if (out_valid) extra++;
                end
                check({name, "_no_extra"}, 64'(extra), 64'(0));
            end
        join
        if (mode == 0) check({name, "_latency"}, 64'(first_out - acc_edge), 64'(3));
        $display("[TB] frame %s: %0d rows, shift %0d, %0d outputs", name, h, sh, nexp);
    endtask

    int k_id[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int k_lap[9] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    int k_one[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int k_a[9];
    int k_b[9];

    task automatic rand_kernel(output int kout[9]);
        for (int i = 0; i < 9; i++) kout[i] = int'($urandom_range(255)) - 128;
    endtask

    initial begin
        int sh;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_pixel", 64'(outputPixel), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // identity on a ramp: outputs are the interior pixels
        load_coefs(k_id);
        cfg_shift = 4'd0;
        fill(0, 10);
        run_frame("ident_ramp", 10, k_id, 0, 0);

        // laplacian
        load_coefs(k_lap);
        fill(1, 10);
        run_frame("lap_flat", 10, k_lap, 0, 1);
        fill(2, 10);
        run_frame("lap_dot", 10, k_lap, 0, 0);

        // box filter with rounding and saturation
        load_coefs(k_one);
        cfg_shift = 4'd3;
        fill(3, 10);
        run_frame("box_255", 10, k_one, 3, 1);
        fill(4, 10);
        run_frame("box_8", 10, k_one, 3, 0);

        // random kernels, stall and random handshakes
        rand_kernel(k_a);
        sh = $urandom_range(5, 8);
        load_coefs(k_a);
        cfg_shift = 4'(sh);
        fill(5, 10);
        run_frame("rand_stall", 10, k_a, sh, 2);
        fill(5, 7);
        run_frame("rand_hs", 7, k_a, sh, 1);

        // coefficient writes mid-frame only take effect at the next SOF
        rand_kernel(k_a);
        rand_kernel(k_b);
        load_coefs(k_a);
        cfg_shift = 4'd6;
        fill(5, 8);
        fork
            run_frame("coef_old", 8, k_a, 6, 0);
            begin
                repeat (30) @(posedge clk);
                load_coefs(k_b);
            end
        join
        fill(5, 6);
        run_frame("coef_new", 6, k_b, 6, 1);

        // reset in the middle of a frame
        load_coefs(k_id);
        cfg_shift = 4'd0;
        fill(0, 10);
        out_ready = 1'b1;
        for (int i = 0; i < 43; i++) begin
            @(posedge clk); #1;
            in_valid   = 1'b1;
            inputPixel = fb[i];
            in_sof     = (i == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_out_pixel", 64'(outputPixel), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        rand_kernel(k_a);
        sh = $urandom_range(5, 8);
        load_coefs(k_a);
        cfg_shift = 4'(sh);
        fill(5, 10);
        run_frame("post_rst", 10, k_a, sh, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
